comb_mc: RTL and testbench
==========================

Name: comb_mc

Overview:
- Parametrised multichannel CIC comb stage: y[n] = x[n] − x[n−M] per channel, with configurable differential delay M and NCH time-interleaved channels.
- Successor to the single-channel, M=1 comb. Sits between the decimator and the next comb or the output scaler in the CIC chain.
- Adds channel tagging, frame realignment, history clear and bypass mode.

Parameters:
- Win, 16, input sample width (signed two's complement)
- M, 1, differential delay in samples per channel; legal range 1..8
- NCH, 4, number of time-interleaved channels; legal range 1..16, power of two not required
- CHW, $clog2(NCH) (minimum 1), channel index width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- val_in  in  1  input sample valid, one sample per asserted cycle
- data_in  in  Win  signed input sample
- sof_in  in  1  start-of-frame; qualifies a val_in sample as channel 0
- clr  in  1  synchronous clear of history and channel counter
- bypass  in  1  when 1, output is sign-extended data_in (no subtraction)
- val_out  out  1  output valid
- data_out  out  Win+1  signed comb result
- ch_out  out  CHW  channel index of data_out

Behaviour:
- Reset (async, rst=1): val_out=0, data_out=0, ch_out=0, channel counter=0, all history words=0.
- Latency: exactly 1 clock. val_in sampled at edge k gives val_out=1 after edge k, for one cycle. val_out follows val_in cycle-for-cycle, with no bubbles added or removed.
- val_in=0: history, counter and data_out hold; val_out=0.
- History is a shift register of NCH*M words of Win bits. It advances only on a val_in cycle. The word leaving the tail is x[n−M] of the current channel, because channels are strictly round-robin.
- Arithmetic: both operands are sign-extended to Win+1 bits before the subtraction. The result always fits in Win+1 bits; no saturation or wrap logic is needed. Worst case: (−2^(Win−1)) − (2^(Win−1)−1) = −2^Win+1.
- Channel counter: increments on each val_in and wraps NCH−1 → 0. ch_out is the counter value registered with the sample.
- sof_in with val_in: the sample is forced to channel 0 and the counter becomes 1 (wraps to 0 when NCH=1). If the counter was not already 0, history is zeroed in the same cycle before the shift. The sample is then combed against 0.
- sof_in without val_in: ignored.
- clr=1: history and counter go to 0 at the next edge, val_out=0, and any val_in in that cycle is dropped. clr has priority over val_in and sof_in. data_out holds.
- bypass=1: data_out = sign-extended data_in. History still shifts normally, so clearing bypass produces correct comb output immediately.
- Start-up: after reset or clear, the first M samples of each channel output x itself, since history is 0.
- rst asserted mid-stream: everything clears immediately; no partial output is emitted.

Decomposition:
- Package comb_pkg holds:
  - function clog2_min1(n)
  - localparam MAX_M=8 and MAX_NCH=16, used for elaboration-time range assertions
- Sub-module comb_dly: parametrised shift register, depth D = NCH*M, width Win, with enable and synchronous zero. Instantiated once.
- The subtractor, counter, sof/clr logic and output register live in comb_mc.

Test Plan:
- NCH=1, M=1, Win=16, continuous ramp 0,1,2,…,99 → first output 0, then 1 on every following sample. 100 outputs, 0 mismatches against golden file odata_comb1.txt.
- NCH=4, M=2, channel c fed constant 100*(c+1) → first 8 outputs 100,200,300,400,100,200,300,400, then 0 thereafter. ch_out cycles 0,1,2,3.
- Extremes, Win=16, M=1, NCH=1: x = 32767 then −32768 → data_out = 32767 then −65535, both exact in 17 bits.
- Gapped val_in, random 30% idle cycles, NCH=2, M=3 → outputs identical to the gap-free reference sequence. val_out count equals val_in count. Latency 1 on every sample.
- Realignment, NCH=4: assert sof_in with the counter at 2, sample 500 → ch_out=0, data_out=500, history zeroed. The next sample is tagged channel 1.
- clr and bypass: clr together with val_in → no val_out and history zero. bypass=1 with input −5 → data_out=−5. After bypass drops, the next output equals x[n]−x[n−M] using the history shifted during bypass.

Source files
------------

// File: rtl/comb_pkg.sv
// comb_pkg: shared limits and helpers for the multichannel comb stage
package comb_pkg;
  localparam int MAX_M = 8;
  localparam int MAX_NCH = 16;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/comb_dly.sv
// comb_dly: enabled shift register with synchronous zero; q_o is the oldest word
module comb_dly #(
  parameter int D = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         zero_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q [D];
  // zero and shift together leave only the new word in the head slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= en_i ? d_i : zero_i ? '0 : sr_q[0];
      for (int i = 1; i < D; i++) sr_q[i] <= zero_i ? '0 : en_i ? sr_q[i-1] : sr_q[i];
    end
  end
  assign q_o = sr_q[D-1];
endmodule

// File: rtl/comb_mc.sv
// comb_mc: multichannel CIC comb y = x[n] - x[n-M] with sof realign, clear and bypass
module comb_mc
  import comb_pkg::*;
#(
  parameter int Win = 16,
  parameter int M   = 1,
  parameter int NCH = 4,
  parameter int CHW = clog2_min1(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  val_in,
  input  logic signed [Win-1:0] data_in,
  input  logic                  sof_in,
  input  logic                  clr,
  input  logic                  bypass,
  output logic                  val_out,
  output logic signed [Win:0]   data_out,
  output logic [CHW-1:0]        ch_out
);
  if (M < 1 || M > MAX_M) begin : g_bad_m
    $error("comb_mc: M out of range");
  end
  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("comb_mc: NCH out of range");
  end
  logic                  en, zero, val_q;
  logic [CHW-1:0]        cnt_q, cnt_d, ch, ch_q;
  logic signed [Win-1:0] tail;
  logic signed [Win:0]   data_q, data_d;
  comb_dly #(.D(NCH*M), .W(Win)) u_dly (
    .clk   (clk),
    .rst   (rst),
    .en_i  (en),
    .zero_i(zero),
    .d_i   (data_in),
    .q_o   (tail)
  );
  // clr wins over any sample; a misaligned sof wipes history and combs against zero
  always_comb begin
    en = val_in && !clr;
    ch = sof_in ? '0 : cnt_q;
    zero = clr || (en && sof_in && cnt_q != '0);
    cnt_d = clr ? '0 : !en ? cnt_q : (ch == CHW'(NCH-1)) ? '0 : ch + 1'b1;
    data_d = bypass ? (Win+1)'(data_in) : (Win+1)'(data_in) - (zero ? '0 : (Win+1)'(tail));
  end
  // single-cycle output register; data and tag hold between samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 1'b0;
      cnt_q <= '0;
      ch_q <= '0;
      data_q <= '0;
    end else begin
      val_q <= en;
      cnt_q <= cnt_d;
      if (en) begin
        data_q <= data_d;
        ch_q <= ch;
      end
    end
  end
  assign val_out = val_q;
  assign data_out = data_q;
  assign ch_out = ch_q;
endmodule

// File: tb/tb_comb_mc.sv
// tb_comb_mc: directed checks on three comb_mc configurations sharing one clock
module tb_comb_mc;
  logic clk = 0;
  logic rst = 1;
  logic val [3];
  logic sof [3];
  logic clr [3];
  logic byp [3];
  logic signed [15:0] din [3];
  logic vo [3];
  logic signed [16:0] dout [3];
  logic [0:0] ch_a, ch_c;
  logic [1:0] ch_b;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  comb_mc #(.Win(16), .M(1), .NCH(1)) u_a (.clk(clk), .rst(rst), .val_in(val[0]), .data_in(din[0]),
    .sof_in(sof[0]), .clr(clr[0]), .bypass(byp[0]), .val_out(vo[0]), .data_out(dout[0]), .ch_out(ch_a));
  comb_mc #(.Win(16), .M(2), .NCH(4)) u_b (.clk(clk), .rst(rst), .val_in(val[1]), .data_in(din[1]),
    .sof_in(sof[1]), .clr(clr[1]), .bypass(byp[1]), .val_out(vo[1]), .data_out(dout[1]), .ch_out(ch_b));
  comb_mc #(.Win(16), .M(3), .NCH(2)) u_c (.clk(clk), .rst(rst), .val_in(val[2]), .data_in(din[2]),
    .sof_in(sof[2]), .clr(clr[2]), .bypass(byp[2]), .val_out(vo[2]), .data_out(dout[2]), .ch_out(ch_c));

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int u, input bit v, input int d, input bit s = 0, input bit c = 0, input bit b = 0);
    val[u] = v;
    din[u] = 16'(d);
    sof[u] = s;
    clr[u] = c;
    byp[u] = b;
    @(posedge clk);
    #1;
    val[u] = 0;
    sof[u] = 0;
    clr[u] = 0;
  endtask

  task automatic chk_out(input string tag, input int u, input int v, input int d, input int ch);
    int got_ch;
    got_ch = (u == 0) ? int'(ch_a) : (u == 1) ? int'(ch_b) : int'(ch_c);
    chk({tag, "_val"}, int'(vo[u]), v);
    chk({tag, "_data"}, int'(dout[u]), d);
    chk({tag, "_ch"}, got_ch, ch);
  endtask

  initial begin
    int xs [30];
    int n, cyc, outs;
    for (int u = 0; u < 3; u++) begin
      val[u] = 0; sof[u] = 0; clr[u] = 0; byp[u] = 0; din[u] = '0;
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) chk_out("reset", u, 0, 0, 0);
    rst = 0;
    // single channel, M=1: ramp gives 0 then a constant 1
    for (int i = 0; i < 100; i++) begin
      step(0, 1, i);
      chk_out("ramp", 0, 1, (i == 0) ? 0 : 1, 0);
    end
    // clr with a sample: dropped, data holds, history cleared
    step(0, 1, 1234, 0, 1);
    chk_out("clr_drop", 0, 0, 1, 0);
    step(0, 1, 32767);
    chk_out("ext_max", 0, 1, 32767, 0);
    step(0, 1, -32768);
    chk_out("ext_min", 0, 1, -65535, 0);
    step(0, 1, -5, 0, 0, 1);
    chk_out("bypass", 0, 1, -5, 0);
    step(0, 1, 10);
    chk_out("after_byp", 0, 1, 15, 0);
    step(0, 1, 77, 0, 1);
    chk_out("clr_hold", 0, 0, 15, 0);
    step(0, 1, 3);
    chk_out("after_clr", 0, 1, 3, 0);
    // four channels, M=2: constants pass for two rounds then cancel
    for (int i = 0; i < 14; i++) begin
      step(1, 1, 100 * (i % 4 + 1));
      chk_out("const4", 1, 1, (i < 8) ? 100 * (i % 4 + 1) : 0, i % 4);
    end
    step(1, 0, 0, 1);
    chk_out("sof_idle", 1, 0, 0, 1);
    step(1, 1, 500, 1);
    chk_out("sof_realign", 1, 1, 500, 0);
    step(1, 1, 7);
    chk_out("post_sof", 1, 1, 7, 1);
    step(1, 1, 9);
    chk_out("post_sof2", 1, 1, 9, 2);
    // two channels, M=3, randomly gapped input vs the gap-free reference
    for (int i = 0; i < 30; i++) xs[i] = (i * 37) % 200 - 100;
    n = 0; cyc = 0; outs = 0;
    while (n < 30 && cyc < 300) begin
      cyc++;
      if ($urandom_range(0, 9) < 3) begin
        step(2, 0, 0);
        chk("gap_idle", int'(vo[2]), 0);
      end else begin
        step(2, 1, xs[n]);
        chk_out("gap", 2, 1, xs[n] - ((n >= 6) ? xs[n-6] : 0), n % 2);
        n++;
      end
      if (vo[2]) outs++;
    end
    chk("gap_in", n, 30);
    chk("gap_out", outs, 30);
    // async reset clears every output without waiting for an edge
    #2 rst = 1;
    #1;
    chk_out("rst_mid", 1, 0, 0, 0);
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
